// File: rtl/bcd_counter_n.sv
// bcd_counter_n: N-digit packed-BCD up/down counter with synchronous load,
// count enable, terminal-count decode and wrap or saturate behaviour at the
// ends. All stepping is done digit by digit in BCD; no binary count exists.
module bcd_counter_n #(
  parameter int DIGITS    = 3,
  parameter int MAX_COUNT = 999,
  parameter bit WRAP      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  done,
  output logic                  zero,
  output logic                  carry,
  output logic                  err
);

  localparam int W = 4 * DIGITS;

  // Elaboration-time conversion of the decimal terminal value to packed BCD.
  function automatic logic [W-1:0] to_bcd(input int value);
    logic [W-1:0] r;
    int           v;
    r = '0;
    v = value;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_COUNT);

  // True when every nibble holds a legal decimal digit.
  function automatic logic bcd_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      ok = ok & (v[4*i +: 4] <= 4'd9);
    end
    return ok;
  endfunction

  // Ripple a +1 through the digits: 9 rolls to 0 and carries onward.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c && (v[4*i +: 4] == 4'd9)) begin
        r[4*i +: 4] = 4'd0;
      end else if (c) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
        c = 1'b0;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Ripple a -1 through the digits: 0 rolls to 9 and borrows onward.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b && (v[4*i +: 4] == 4'd0)) begin
        r[4*i +: 4] = 4'd9;
      end else if (b) begin
        r[4*i +: 4] = v[4*i +: 4] - 4'd1;
        b = 1'b0;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  logic [W-1:0] count_r;
  logic [W-1:0] count_s;
  logic         carry_r;
  logic         carry_s;
  logic         err_r;
  logic         err_s;

  // Next-state selection: load beats count, count beats hold.
  always_comb begin
    count_s = count_r;
    carry_s = 1'b0;
    err_s   = 1'b0;
    if (load) begin
      if (bcd_valid(load_val) && (load_val <= MAX_BCD)) begin
        count_s = load_val;
      end else begin
        err_s = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (count_r == MAX_BCD) begin
          if (WRAP) begin
            count_s = '0;
            carry_s = 1'b1;
          end else begin
            count_s = count_r;
          end
        end else begin
          count_s = bcd_inc(count_r);
        end
      end else begin
        if (count_r == '0) begin
          if (WRAP) begin
            count_s = MAX_BCD;
            carry_s = 1'b1;
          end else begin
            count_s = count_r;
          end
        end else begin
          count_s = bcd_dec(count_r);
        end
      end
    end else begin
      count_s = count_r;
    end
  end

  // Count and pulse registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
      carry_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      count_r <= count_s;
      carry_r <= carry_s;
      err_r   <= err_s;
    end
  end

  assign bcd_out = count_r;
  assign carry   = carry_r;
  assign err     = err_r;
  assign done    = (count_r == MAX_BCD);
  assign zero    = (count_r == '0);

endmodule

// File: tb/tb_bcd_counter_n.sv
// Self-checking bench for bcd_counter_n: three configurations driven side by
// side, every edge compared against an integer reference model, plus a vector
// table and hand-written terminal/reset sequences.
module tb_bcd_counter_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        en_a [3];
  logic        up_a [3];
  logic        ld_a [3];
  logic [11:0] lv_a [3];

  logic [11:0] q0, q2;
  logic [7:0]  q1;
  logic dn0, dn1, dn2, z0, z1, z2, c0, c1, c2, e0, e1, e2;

  bcd_counter_n dut0 (
    .clk(clk), .rst(rst), .en(en_a[0]), .up(up_a[0]), .load(ld_a[0]),
    .load_val(lv_a[0]), .bcd_out(q0), .done(dn0), .zero(z0), .carry(c0), .err(e0));

  bcd_counter_n #(.DIGITS(2), .MAX_COUNT(59), .WRAP(1'b0)) dut1 (
    .clk(clk), .rst(rst), .en(en_a[1]), .up(up_a[1]), .load(ld_a[1]),
    .load_val(lv_a[1][7:0]), .bcd_out(q1), .done(dn1), .zero(z1), .carry(c1), .err(e1));

  bcd_counter_n #(.DIGITS(3), .MAX_COUNT(100), .WRAP(1'b1)) dut2 (
    .clk(clk), .rst(rst), .en(en_a[2]), .up(up_a[2]), .load(ld_a[2]),
    .load_val(lv_a[2]), .bcd_out(q2), .done(dn2), .zero(z2), .carry(c2), .err(e2));

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: plain decimal integers per instance.
  int M_MAX  [3] = '{999, 59, 100};
  int M_DIG  [3] = '{3, 2, 3};
  bit M_WRAP [3] = '{1'b1, 1'b0, 1'b1};
  int m_val  [3];
  bit m_c    [3];
  bit m_e    [3];

  function automatic logic [11:0] tobcd(input int value);
    logic [11:0] r;
    int v;
    r = 12'h000;
    v = value;
    for (int d = 0; d < 3; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic mreset();
    for (int k = 0; k < 3; k++) begin
      m_val[k] = 0; m_c[k] = 1'b0; m_e[k] = 1'b0;
    end
  endtask

  task automatic mstep(input int k);
    int dec;
    bit ok;
    m_c[k] = 1'b0;
    m_e[k] = 1'b0;
    if (ld_a[k]) begin
      ok = 1'b1;
      dec = 0;
      for (int d = M_DIG[k] - 1; d >= 0; d--) begin
        if (lv_a[k][4*d +: 4] > 4'd9) ok = 1'b0;
        dec = dec * 10 + int'(lv_a[k][4*d +: 4]);
      end
      if (ok && dec <= M_MAX[k]) m_val[k] = dec;
      else m_e[k] = 1'b1;
    end else if (en_a[k]) begin
      if (up_a[k]) begin
        if (m_val[k] == M_MAX[k]) begin
          if (M_WRAP[k]) begin m_val[k] = 0; m_c[k] = 1'b1; end
        end else m_val[k] = m_val[k] + 1;
      end else begin
        if (m_val[k] == 0) begin
          if (M_WRAP[k]) begin m_val[k] = M_MAX[k]; m_c[k] = 1'b1; end
        end else m_val[k] = m_val[k] - 1;
      end
    end
  endtask

  task automatic check_all();
    logic [11:0] q;
    logic d, z, c, e;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin q = q0; d = dn0; z = z0; c = c0; e = e0; end
        1: begin q = {4'h0, q1}; d = dn1; z = z1; c = c1; e = e1; end
        default: begin q = q2; d = dn2; z = z2; c = c2; e = e2; end
      endcase
      chk($sformatf("model_q%0d", k), 32'(q), 32'(tobcd(m_val[k])));
      chk($sformatf("model_done%0d", k), 32'(d), 32'(m_val[k] == M_MAX[k]));
      chk($sformatf("model_zero%0d", k), 32'(z), 32'(m_val[k] == 0));
      chk($sformatf("model_carry%0d", k), 32'(c), 32'(m_c[k]));
      chk($sformatf("model_err%0d", k), 32'(e), 32'(m_e[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) mstep(k);
    #1;
    check_all();
  endtask

  task automatic idle();
    for (int k = 0; k < 3; k++) begin
      en_a[k] = 1'b0; up_a[k] = 1'b1; ld_a[k] = 1'b0; lv_a[k] = 12'h000;
    end
  endtask

  typedef struct {
    logic        en;
    logic        up;
    logic        load;
    logic [11:0] lv;
    logic [11:0] q;
    logic        carry;
    logic        err;
  } vec_t;

  vec_t tbl [13];

  initial begin
    // Vectors for the MAX_COUNT=100 instance starting from zero.
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 12'h5A3, 12'h000, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 12'h123, 12'h000, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 12'h098, 12'h098, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 12'h000, 12'h099, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 12'h000, 12'h100, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 12'h000, 12'h100, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 12'h000, 12'h099, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 12'h101, 12'h099, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h099, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 12'h050, 12'h050, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 12'h050, 12'h049, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h049, 1'b0, 1'b0};

    idle();
    rst = 1'b1;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_zero0", 32'(z0), 32'd1);
    chk("rst_done0", 32'(dn0), 32'd0);
    #2 rst = 1'b0;

    // Count five, then an asynchronous reset mid-cycle.
    en_a[0] = 1'b1; up_a[0] = 1'b1;
    repeat (5) tick();
    chk("pre_rst_q", 32'(q0), 32'h005);
    #2 rst = 1'b1;
    #1;
    mreset();
    chk("async_rst_q", 32'(q0), 32'h000);
    chk("async_rst_zero", 32'(z0), 32'd1);
    #20 rst = 1'b0;
    tick();
    chk("resume_q", 32'(q0), 32'h001);
    en_a[0] = 1'b0;

    // Vector table on the MAX_COUNT=100 instance.
    for (int i = 0; i < 13; i++) begin
      en_a[2] = tbl[i].en; up_a[2] = tbl[i].up;
      ld_a[2] = tbl[i].load; lv_a[2] = tbl[i].lv;
      tick();
      chk($sformatf("tbl%0d_q", i), 32'(q2), 32'(tbl[i].q));
      chk($sformatf("tbl%0d_carry", i), 32'(c2), 32'(tbl[i].carry));
      chk($sformatf("tbl%0d_err", i), 32'(e2), 32'(tbl[i].err));
    end
    idle();

    // Full up sweep from 000 on the default instance.
    ld_a[0] = 1'b1; lv_a[0] = 12'h000;
    tick();
    ld_a[0] = 1'b0; en_a[0] = 1'b1; up_a[0] = 1'b1;
    repeat (999) tick();
    chk("sweep_999", 32'(q0), 32'h999);
    chk("sweep_done", 32'(dn0), 32'd1);
    tick();
    chk("sweep_wrap_q", 32'(q0), 32'h000);
    chk("sweep_wrap_carry", 32'(c0), 32'd1);

    // Down from 000, then a 10 -> 09 borrow.
    up_a[0] = 1'b0;
    tick();
    chk("down_wrap_q", 32'(q0), 32'h999);
    chk("down_wrap_carry", 32'(c0), 32'd1);
    tick();
    chk("down_998", 32'(q0), 32'h998);
    chk("down_carry_clear", 32'(c0), 32'd0);
    tick();
    chk("down_997", 32'(q0), 32'h997);
    ld_a[0] = 1'b1; lv_a[0] = 12'h010;
    tick();
    ld_a[0] = 1'b0;
    tick();
    chk("borrow_009", 32'(q0), 32'h009);
    idle();

    // Saturating two-digit instance.
    en_a[1] = 1'b1; up_a[1] = 1'b1;
    repeat (70) tick();
    chk("sat_up_q", 32'(q1), 32'h59);
    chk("sat_up_done", 32'(dn1), 32'd1);
    chk("sat_up_carry", 32'(c1), 32'd0);
    up_a[1] = 1'b0;
    repeat (70) tick();
    chk("sat_dn_q", 32'(q1), 32'h00);
    chk("sat_dn_zero", 32'(z1), 32'd1);
    chk("sat_dn_carry", 32'(c1), 32'd0);
    idle();

    // Load and enable together: load wins.
    en_a[0] = 1'b1; up_a[0] = 1'b1; ld_a[0] = 1'b1; lv_a[0] = 12'h998;
    tick();
    chk("ld_en_q", 32'(q0), 32'h998);
    ld_a[0] = 1'b0;
    tick();
    chk("ld_en_999", 32'(q0), 32'h999);
    chk("ld_en_done", 32'(dn0), 32'd1);
    tick();
    chk("ld_en_wrap", 32'(q0), 32'h000);
    chk("ld_en_carry", 32'(c0), 32'd1);
    idle();

    // Randomised traffic on all instances against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 3; k++) begin
        en_a[k] = ($urandom_range(0, 3) != 0);
        up_a[k] = 1'($urandom_range(0, 1));
        ld_a[k] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 1) == 1) lv_a[k] = tobcd(int'($urandom_range(0, 999)));
        else lv_a[k] = 12'($urandom);
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
